// File: rtl/times_table_checker.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// times_table_checker
//
// Self-test front end for the 8x8 times-table memory stage. On a start request
// it issues all 64 {a,b} operand pairs in ascending order with the read enable
// high. It lines up each returned result with the address that produced it and
// compares the result against a*b. It then counts the mismatches, remembers the
// first failing address, and reports pass/fail when the sweep completes.
//
// Parameters:
//   READ_LATENCY   cycles from a/b/enable presented to result valid (1..4)
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   start           one-cycle sweep request, honoured only while idle
//   result[5:0]     product returned by the memory stage
//   a[2:0], b[2:0]  operands to the memory stage
//   enable          read enable to the memory stage
//   busy            high from sweep start until done
//   done            one-cycle pulse at sweep completion
//   pass            last completed sweep had zero mismatches
//   err_count[6:0]  mismatches in the current/last sweep (0..64)
//   first_err_addr  {a,b} of the first mismatch, 0 if none
//   err_seen        a mismatch has been recorded in the current/last sweep
// -----------------------------------------------------------------------------
module times_table_checker #(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] result,
    output logic [2:0] a,
    output logic [2:0] b,
    output logic       enable,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_count,
    output logic [5:0] first_err_addr,
    output logic       err_seen
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(READ_LATENCY - 1);
    localparam logic [6:0] ERR_MAX    = 7'd64;

    state_t     state_q;
    logic [5:0] addr_q;        // issue counter, {a,b}
    logic       enable_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [1:0] drain_cnt_q;

    logic [6:0] err_count_q, err_count_d;
    logic [5:0] first_err_q, first_err_d;
    logic       err_seen_q,  err_seen_d;

    // Alignment pipeline: stage i holds what was issued i+1 cycles ago.
    logic       pipe_valid_q [READ_LATENCY];
    logic [5:0] pipe_addr_q  [READ_LATENCY];

    logic       start_accept;
    logic       cmp_valid;
    logic [5:0] cmp_addr;
    logic [5:0] expected;
    logic       mismatch;

    assign start_accept = (state_q == S_IDLE) && start;

    assign cmp_valid = pipe_valid_q[READ_LATENCY-1];
    assign cmp_addr  = pipe_addr_q[READ_LATENCY-1];
    // Operands widened to 6 bits so the product (max 49) is kept whole.
    assign expected  = {3'b000, cmp_addr[5:3]} * {3'b000, cmp_addr[2:0]};
    assign mismatch  = cmp_valid && (result != expected);

    // -------------------------------------------------------------------------
    // Error bookkeeping. A new sweep clears the history; otherwise a mismatch
    // bumps the saturating count, and only the first one latches its address.
    // -------------------------------------------------------------------------
    always_comb begin
        err_count_d = err_count_q;
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;
        if (start_accept) begin
            err_count_d = '0;
            first_err_d = '0;
            err_seen_d  = 1'b0;
        end else if (mismatch) begin
            if (err_count_q != ERR_MAX) begin
                err_count_d = err_count_q + 7'd1;
            end
            if (!err_seen_q) begin
                first_err_d = cmp_addr;
                err_seen_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
        end else begin
            err_count_q <= err_count_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
        end
    end

    // -------------------------------------------------------------------------
    // Alignment shift register, fed with whatever is on the memory port now.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_addr_q[i]  <= '0;
            end
        end else begin
            pipe_valid_q[0] <= enable_q;
            pipe_addr_q[0]  <= addr_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_addr_q[i]  <= pipe_addr_q[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer with registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            drain_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_q   <= '0;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    if (start) begin
                        state_q  <= S_SWEEP;
                        enable_q <= 1'b1;
                        busy_q   <= 1'b1;
                        pass_q   <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    // Leave on the last address so the counter never wraps
                    // back to 0 with the enable still asserted.
                    if (addr_q == 6'd63) begin
                        state_q     <= S_DRAIN;
                        enable_q    <= 1'b0;
                        addr_q      <= '0;
                        drain_cnt_q <= '0;
                    end else begin
                        addr_q <= addr_q + 6'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // The final compare lands on this same edge, so the
                        // verdict is taken from the updated count.
                        pass_q  <= (err_count_d == 7'd0);
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign a              = addr_q[5:3];
    assign b              = addr_q[2:0];
    assign enable         = enable_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_q;
    assign err_seen       = err_seen_q;

endmodule

// File: tb/tb_times_table_checker.sv
`timescale 1ns/1ps
// Bench for times_table_checker: two instances (read latency 1 and 2), each fed
// by a behavioural memory model; sweeps are scored against expectations taken
// from a table or from an arithmetic model of what the memory returns.
module tb_times_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [5:0] res1, res2;

    logic [2:0] a1, b1, a2, b2;
    logic       en1, busy1, done1, pass1, seen1;
    logic       en2, busy2, done2, pass2, seen2;
    logic [6:0] ec1, ec2;
    logic [5:0] fe1, fe2;

    int checks = 0;
    int errors = 0;

    times_table_checker #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .result(res1),
        .a(a1), .b(b1), .enable(en1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(ec1), .first_err_addr(fe1), .err_seen(seen1)
    );

    times_table_checker #(.READ_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .result(res2),
        .a(a2), .b(b2), .enable(en2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(ec2), .first_err_addr(fe2), .err_seen(seen2)
    );

    // ---------------- memory models ----------------
    // mode 0: correct, 1-cycle   mode 1: stuck at 0   mode 2: 7x7 reads 48
    // mode 3: correct but 2-cycle latency            mode 4: random faults
    int         mode = 0;
    logic [63:0] fault_mask = '0;
    logic [5:0] fault_xor [64];

    logic [5:0] m1_d1 = '0, m1_d2 = '0, m2_d1 = '0, m2_d2 = '0;

    function automatic logic [5:0] prod(input logic [5:0] ad);
        int x;
        x = int'(ad) / 8 * (int'(ad) % 8);
        return 6'(x);
    endfunction

    always @(posedge clk) begin
        m1_d1 <= {a1, b1};
        m1_d2 <= m1_d1;
        m2_d1 <= {a2, b2};
        m2_d2 <= m2_d1;
    end

    always_comb begin
        res1 = prod(m1_d1);
        case (mode)
            1: res1 = 6'd0;
            2: res1 = (m1_d1 == 6'd63) ? 6'd48 : prod(m1_d1);
            3: res1 = prod(m1_d2);
            4: res1 = prod(m1_d1) ^ (fault_mask[m1_d1] ? fault_xor[m1_d1] : 6'd0);
            default: res1 = prod(m1_d1);
        endcase
    end
    assign res2 = prod(m2_d2);

    // ---------------- reference model of a whole sweep ----------------
    task automatic model_sweep(input int md, output int cnt, output int first,
                               output bit seen, output bit pss);
        int got, want;
        cnt = 0; first = 0; seen = 0;
        for (int i = 0; i < 64; i++) begin
            want = (i / 8) * (i % 8);
            case (md)
                1: got = 0;
                2: got = (i == 63) ? 48 : want;
                3: got = (i == 0) ? 0 : ((i - 1) / 8) * ((i - 1) % 8);
                4: got = fault_mask[i] ? (want ^ int'(fault_xor[i])) : want;
                default: got = want;
            endcase
            if (got != want) begin
                if (!seen) first = i;
                seen = 1;
                if (cnt < 64) cnt++;
            end
        end
        pss = (cnt == 0);
    endtask

    task automatic check_eq(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- one full sweep with timing checks ----------------
    task automatic run_sweep(input string name, input bit use2, input bit hold,
                             input int exp_cnt, input int exp_first,
                             input bit exp_seen, input bit exp_pass);
        int lat, bad, dones, done_at;
        int ec, fe, sn, ps;
        logic en_s, bsy_s, dn_s;
        logic [5:0] ad_s;
        lat = use2 ? 2 : 1;
        bad = 0; dones = 0; done_at = -1;
        ec = -1; fe = -1; sn = -1; ps = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 70 + lat; n++) begin
            if (n > 1) @(negedge clk);
            if (!hold || n == 66 + lat) start = 1'b0;
            en_s  = use2 ? en2   : en1;
            bsy_s = use2 ? busy2 : busy1;
            dn_s  = use2 ? done2 : done1;
            ad_s  = use2 ? {a2, b2} : {a1, b1};
            if (n <= 64) begin
                if (!en_s || !bsy_s || int'(ad_s) != n - 1) bad++;
            end else if (n < 65 + lat) begin
                if (en_s || !bsy_s || ad_s != 6'd0) bad++;
            end else begin
                if (en_s || bsy_s) bad++;
            end
            if (dn_s) begin
                dones++;
                if (done_at < 0) begin
                    done_at = n;
                    ec = use2 ? int'(ec2)   : int'(ec1);
                    fe = use2 ? int'(fe2)   : int'(fe1);
                    sn = use2 ? int'(seen2) : int'(seen1);
                    ps = use2 ? int'(pass2) : int'(pass1);
                end
            end
        end
        check_eq({name, ".issue_seq_bad_cycles"}, bad, 0);
        check_eq({name, ".done_pulses"}, dones, 1);
        check_eq({name, ".done_cycle"}, done_at, 65 + lat);
        check_eq({name, ".err_count"}, ec, exp_cnt);
        check_eq({name, ".first_err_addr"}, fe, exp_first);
        check_eq({name, ".err_seen"}, sn, int'(exp_seen));
        check_eq({name, ".pass"}, ps, int'(exp_pass));
        check_eq({name, ".pass_held"}, use2 ? int'(pass2) : int'(pass1), int'(exp_pass));
        $display("sweep %s: err_count=%0d first=%0d seen=%0d pass=%0d done@%0d",
                 name, ec, fe, sn, ps, done_at);
    endtask

    typedef struct {
        string name;
        int    md;
        int    cnt;
        int    first;
        bit    seen;
        bit    pss;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, first;
        bit seen, pss;
        int dones;

        tbl[0] = '{"clean",       0,  0,  0, 1'b0, 1'b1};
        tbl[1] = '{"stuck_zero",  1, 49,  9, 1'b1, 1'b0};
        tbl[2] = '{"corrupt_7x7", 2,  1, 63, 1'b1, 1'b0};
        tbl[3] = '{"clean_again", 0,  0,  0, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 64; i++) fault_xor[i] = 6'd1;
        repeat (3) @(negedge clk);
        check_eq("reset_state_l1", int'({a1, b1, en1, busy1, done1, pass1, ec1, fe1, seen1}), 0);
        check_eq("reset_state_l2", int'({a2, b2, en2, busy2, done2, pass2, ec2, fe2, seen2}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven sweeps against the latency-1 instance.
        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].md;
            run_sweep(tbl[i].name, 1'b0, 1'b0, tbl[i].cnt, tbl[i].first,
                      tbl[i].seen, tbl[i].pss);
        end

        // Latency-2 instance with its matching 2-cycle memory.
        mode = 0;
        run_sweep("lat2_clean", 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);

        // Same 2-cycle memory behind the latency-1 instance: misaligned.
        mode = 3;
        model_sweep(3, cnt, first, seen, pss);
        run_sweep("lat1_misaligned", 1'b0, 1'b0, cnt, first, seen, pss);
        check_eq("misaligned_has_errors", int'(ec1 > 7'd0), 1);

        // start held high across the whole sweep and the DONE cycle.
        mode = 0;
        run_sweep("start_held", 1'b0, 1'b1, 0, 0, 1'b0, 1'b1);

        // Random fault patterns scored by the reference model.
        for (int r = 0; r < 4; r++) begin
            mode = 4;
            fault_mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            for (int i = 0; i < 64; i++) fault_xor[i] = 6'($urandom_range(1, 63));
            model_sweep(4, cnt, first, seen, pss);
            run_sweep($sformatf("random_%0d", r), 1'b0, 1'b0, cnt, first, seen, pss);
        end

        // Reset asserted during issue cycle 30.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        check_eq("pre_reset_addr", int'({a1, b1}), 29);
        check_eq("pre_reset_has_errors", int'(ec1 > 7'd0), 1);
        rst_n = 1'b0;
        #1;
        check_eq("midsweep_reset_clear", int'({a1, b1, en1, busy1, done1, pass1, ec1, fe1, seen1}), 0);
        dones = 0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (n == 3) rst_n = 1'b1;
            if (done1 || busy1 || en1) dones++;
        end
        check_eq("post_reset_quiet_cycles", dones, 0);
        mode = 0;
        run_sweep("post_reset_clean", 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
